// File: rtl/vc_plane_egress_scheduler.sv
// Per-VC flit FIFOs drained only while their plane is active on plane_sel,
// plus a sticky monitor that the selector steps 0..VC-1 and wraps.
module vc_plane_egress_scheduler #(
  parameter  int VC    = 4,
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  localparam int VCW   = $clog2(VC)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [VC:0]    plane_sel,
  input  logic           in_valid,
  input  logic [VCW-1:0] in_vc,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [VCW-1:0] out_vc,
  output logic [DW-1:0]  out_data,
  input  logic           out_ready,
  output logic [VC-1:0]  vc_full,
  output logic [VC-1:0]  vc_empty,
  output logic           seq_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = VC + 1;

  typedef enum logic {DISARMED, ARMED} mon_t;

  logic [DW-1:0] mem_q    [VC][DEPTH];
  logic [PW-1:0] wr_ptr_q [VC];
  logic [PW-1:0] wr_ptr_d [VC];
  logic [PW-1:0] rd_ptr_q [VC];
  logic [PW-1:0] rd_ptr_d [VC];
  logic [CW-1:0] cnt_q    [VC];
  logic [CW-1:0] cnt_d    [VC];
  logic [VC-1:0] push_oh;
  logic [VC-1:0] pop_oh;

  mon_t          mon_q;
  logic [SW-1:0] prev_q;
  logic [SW-1:0] exp_sel;
  logic          seq_error_q;

  // Selection by index compare keeps out-of-range in_vc/plane_sel from indexing arrays.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    for (int unsigned i = 0; i < VC; i++) begin
      vc_full[i]  = (cnt_q[i] == CW'(DEPTH));
      vc_empty[i] = (cnt_q[i] == '0);
      if (in_vc == VCW'(i)) in_ready = (cnt_q[i] != CW'(DEPTH));
      if (plane_sel == SW'(i)) begin
        out_valid = (cnt_q[i] != '0);
        out_data  = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign out_vc = plane_sel[VCW-1:0];

  always_comb begin
    push_oh = '0;
    pop_oh  = '0;
    for (int unsigned i = 0; i < VC; i++) begin
      push_oh[i]  = in_valid & in_ready & (in_vc == VCW'(i));
      pop_oh[i]   = out_valid & out_ready & (plane_sel == SW'(i));
      wr_ptr_d[i] = push_oh[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
      rd_ptr_d[i] = pop_oh[i]  ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
      case ({push_oh[i], pop_oh[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < VC; i++) begin
      if (rst) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end else begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < VC; i++) begin
      if (push_oh[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
    end
  end

  assign exp_sel = (prev_q == SW'(VC - 1)) ? '0 : prev_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_q       <= DISARMED;
      prev_q      <= '0;
      seq_error_q <= 1'b0;
    end else begin
      mon_q  <= ARMED;
      prev_q <= plane_sel;
      if (plane_sel >= SW'(VC) || (mon_q == ARMED && plane_sel != exp_sel))
        seq_error_q <= 1'b1;
    end
  end

  assign seq_error = seq_error_q;

endmodule

// File: tb/tb_vc_plane_egress_scheduler.sv
// Directed bench for vc_plane_egress_scheduler (VC=4, DW=32, DEPTH=4).
module tb_vc_plane_egress_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  plane_sel;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  vc_full;
  logic [3:0]  vc_empty;
  logic        seq_error;

  int checks = 0;
  int errors = 0;
  int ps     = 0;

  vc_plane_egress_scheduler #(.VC(4), .DW(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .plane_sel (plane_sel),
    .in_valid  (in_valid),
    .in_vc     (in_vc),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_vc    (out_vc),
    .out_data  (out_data),
    .out_ready (out_ready),
    .vc_full   (vc_full),
    .vc_empty  (vc_empty),
    .seq_error (seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle on the legal plane rotation; drops in_valid.
  task automatic adv();
    @(posedge clk);
    #1;
    ps        = (ps + 1) % 4;
    plane_sel = 5'(ps);
    in_valid  = 1'b0;
    #1;
  endtask

  task automatic goto(input int t);
    for (int k = 0; k < 4 && ps != t; k++) adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; plane_sel = '0; in_valid = 1'b0; in_vc = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(vc_empty), 32'hF);
    check("rst_full", 32'(vc_full), 32'h0);
    check("rst_oval", 32'(out_valid), 32'h0);
    check("rst_seq", 32'(seq_error), 32'h0);
    for (int i = 0; i < 4; i++) begin
      in_vc = 2'(i);
      #1;
      check("rst_inrdy", 32'(in_ready), 32'h1);
    end
    rst = 1'b0; in_vc = '0;
    #1;

    // single flit to VC2 visible only in the plane-2 slot
    in_valid = 1'b1; in_vc = 2'd2; in_data = 32'hA5; out_ready = 1'b1;
    #1;
    check("t2_inrdy", 32'(in_ready), 32'h1);
    check("t2_p0_oval", 32'(out_valid), 32'h0);
    adv();
    check("t2_p1_oval", 32'(out_valid), 32'h0);
    adv();
    check("t2_p2_oval", 32'(out_valid), 32'h1);
    check("t2_p2_data", out_data, 32'hA5);
    check("t2_p2_vc", 32'(out_vc), 32'h2);
    adv();
    check("t2_p3_oval", 32'(out_valid), 32'h0);
    check("t2_empty2", 32'(vc_empty[2]), 32'h1);
    adv();

    // fill VC1, refused push during pop, then refill and drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_vc = 2'd1; in_data = 32'h10 + 32'(k);
      #1;
      check("t3_fill_rdy", 32'(in_ready), 32'h1);
      adv();
    end
    check("t3_full1", 32'(vc_full[1]), 32'h1);
    in_vc = 2'd1;
    #1;
    check("t3_rdy_full", 32'(in_ready), 32'h0);
    adv();
    out_ready = 1'b1; in_valid = 1'b1; in_vc = 2'd1; in_data = 32'h14;
    #1;
    check("t3_pop_oval", 32'(out_valid), 32'h1);
    check("t3_pop_data", out_data, 32'h10);
    check("t3_pop_rdy", 32'(in_ready), 32'h0);
    adv();
    check("t3_notfull", 32'(vc_full[1]), 32'h0);
    in_valid = 1'b1; in_vc = 2'd1; in_data = 32'h14;
    #1;
    check("t3_repush_rdy", 32'(in_ready), 32'h1);
    adv();
    check("t3_refull", 32'(vc_full[1]), 32'h1);
    for (int k = 0; k < 4; k++) begin
      goto(1);
      check("t3_drain_oval", 32'(out_valid), 32'h1);
      check("t3_drain_data", out_data, 32'h11 + 32'(k));
      adv();
    end
    check("t3_empty1", 32'(vc_empty[1]), 32'h1);

    // held flit survives a plane change with out_ready=0
    out_ready = 1'b0; in_valid = 1'b1; in_vc = 2'd3; in_data = 32'h77;
    #1;
    check("t4_inrdy", 32'(in_ready), 32'h1);
    goto(3);
    check("t4_oval", 32'(out_valid), 32'h1);
    check("t4_data", out_data, 32'h77);
    check("t4_vc", 32'(out_vc), 32'h3);
    adv();
    check("t4_kept", 32'(vc_empty[3]), 32'h0);
    goto(3);
    out_ready = 1'b1;
    #1;
    check("t4_again_oval", 32'(out_valid), 32'h1);
    check("t4_again_data", out_data, 32'h77);
    adv();
    check("t4_empty3", 32'(vc_empty[3]), 32'h1);
    check("t4_seq_ok", 32'(seq_error), 32'h0);

    // selector 0,1,2,3,0,2 then illegal 5
    out_ready = 1'b0; in_valid = 1'b1; in_vc = 2'd1; in_data = 32'h55;
    repeat (4) adv();
    @(posedge clk);
    #1;
    plane_sel = 5'd2;
    #1;
    check("t5_pre", 32'(seq_error), 32'h0);
    @(posedge clk);
    #1;
    plane_sel = 5'd5; out_ready = 1'b1;
    #1;
    check("t5_err", 32'(seq_error), 32'h1);
    check("t5_ill_oval", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    ps = 0; plane_sel = 5'd0;
    #1;
    check("t5_vc1_kept", 32'(vc_empty[1]), 32'h0);
    check("t5_sticky", 32'(seq_error), 32'h1);
    adv();
    check("t5_flow_oval", 32'(out_valid), 32'h1);
    check("t5_flow_data", out_data, 32'h55);
    repeat (4) adv();
    check("t5_sticky2", 32'(seq_error), 32'h1);
    check("t5_empty1", 32'(vc_empty[1]), 32'h1);

    // reset mid-operation discards stored flits
    goto(0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_vc    = (k < 3) ? 2'd0 : 2'd3;
      in_data  = (k < 3) ? 32'h60 + 32'(k) : 32'h70 + 32'(k);
      adv();
    end
    check("t6_loaded", 32'(vc_empty), 32'h6);
    ps = 0; plane_sel = 5'd0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_empty", 32'(vc_empty), 32'hF);
    check("t6_oval", 32'(out_valid), 32'h0);
    check("t6_seq", 32'(seq_error), 32'h0);
    rst = 1'b0; in_valid = 1'b1; in_vc = 2'd0; in_data = 32'hC0;
    #1;
    check("t6_push_rdy", 32'(in_ready), 32'h1);
    check("t6_no_bypass", 32'(out_valid), 32'h0);
    adv();
    in_valid = 1'b1; in_vc = 2'd3; in_data = 32'hC3;
    adv();
    adv();
    out_ready = 1'b1;
    #1;
    check("t6_p3_oval", 32'(out_valid), 32'h1);
    check("t6_p3_data", out_data, 32'hC3);
    adv();
    check("t6_p0_oval", 32'(out_valid), 32'h1);
    check("t6_p0_data", out_data, 32'hC0);
    adv();
    check("t6_final_empty", 32'(vc_empty), 32'hF);
    check("t6_final_seq", 32'(seq_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
